// File: rtl/systolic_skew_feeder.sv
// Pops ROWS FIFOs in lockstep for one VEC_LEN pass and skews row r by r cycles so the
// systolic array sees an aligned wavefront; any empty FIFO stalls the whole column.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int VEC_LEN    = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [ROWS-1:0]              fifo_r_en,
  input  logic [ROWS*DATA_WIDTH-1:0]   fifo_data_out,
  input  logic [ROWS-1:0]              fifo_empty,
  output logic [ROWS*DATA_WIDTH-1:0]   arr_data,
  output logic [ROWS-1:0]              arr_valid
);

  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam int DRN_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   read_cnt_r, read_cnt_s;
  logic [DRN_W-1:0]   drain_cnt_r, drain_cnt_s;
  logic               pop_ok_s;
  logic               pop_d1_r;
  logic               busy_r, done_r;

  // Next-state, counter and pop decode; pop_ok follows this cycle's empty flags directly.
  always_comb begin
    state_s     = state_r;
    read_cnt_s  = read_cnt_r;
    drain_cnt_s = drain_cnt_r;
    pop_ok_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = STREAM;
          read_cnt_s  = {CNT_W{1'b0}};
          drain_cnt_s = {DRN_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        pop_ok_s = ~|fifo_empty;
        if (pop_ok_s) begin
          read_cnt_s = read_cnt_r + CNT_W'(1);
          if (read_cnt_r == CNT_W'(VEC_LEN - 1)) begin
            state_s = DRAIN;
          end else begin
            state_s = STREAM;
          end
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        // ROWS cycles cover the read latency plus the deepest skew stage
        if (drain_cnt_r == DRN_W'(ROWS - 1)) begin
          state_s = DONE;
        end else begin
          drain_cnt_s = drain_cnt_r + DRN_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, stage-0 valid and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      read_cnt_r  <= {CNT_W{1'b0}};
      drain_cnt_r <= {DRN_W{1'b0}};
      pop_d1_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      read_cnt_r  <= read_cnt_s;
      drain_cnt_r <= drain_cnt_s;
      pop_d1_r    <= pop_ok_s;
      busy_r      <= (state_s == STREAM) || (state_s == DRAIN);
      done_r      <= (state_s == DONE);
    end
  end

  assign fifo_r_en = {ROWS{pop_ok_s}};
  assign busy      = busy_r;
  assign done      = done_r;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] stage0_data_s;
    assign stage0_data_s = fifo_data_out[r*DATA_WIDTH +: DATA_WIDTH];

    if (r == 0) begin : g_direct
      assign arr_valid[r] = pop_d1_r;
      assign arr_data[r*DATA_WIDTH +: DATA_WIDTH] =
        pop_d1_r ? stage0_data_s : {DATA_WIDTH{1'b0}};
    end else begin : g_skew
      // each entry is {valid, data}; stalls ride the same diagonal as data
      logic [DATA_WIDTH:0] sh_r [r];

      // Per-row skew shift register, advancing every cycle.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < r; i++) begin
            sh_r[i] <= {(DATA_WIDTH + 1){1'b0}};
          end
        end else begin
          sh_r[0] <= {pop_d1_r, stage0_data_s};
          for (int i = 1; i < r; i++) begin
            sh_r[i] <= sh_r[i-1];
          end
        end
      end

      assign arr_valid[r] = sh_r[r-1][DATA_WIDTH];
      assign arr_data[r*DATA_WIDTH +: DATA_WIDTH] =
        sh_r[r-1][DATA_WIDTH] ? sh_r[r-1][DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Downstream consumer of the per-row sync FIFOs in the TPU datapath. Pops one element from each of ROWS FIFOs in lockstep for a pass of VEC_LEN elements. Delays row r by r cycles (diagonal skew) so the data enters the systolic array wavefront-aligned. Inserts column-wide bubbles whenever any FIFO is empty, so the wavefront stays aligned.

Parameters:
DATA_WIDTH, 16, element width; matches FIFO data width
ROWS, 4, number of row FIFOs / array rows (>=1)
VEC_LEN, 8, elements popped per row per pass (>=1)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle pass request; honoured only in IDLE
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the last skewed element has left
fifo_r_en  output  ROWS  read enable per row FIFO
fifo_data_out  input  ROWS*DATA_WIDTH  FIFO read data; row r at [r*DATA_WIDTH +: DATA_WIDTH]
fifo_empty  input  ROWS  FIFO empty flags
arr_data  output  ROWS*DATA_WIDTH  skewed data to array; same packing
arr_valid  output  ROWS  per-row valid qualifying arr_data

Behaviour:
- Reset: the async assertion of rstn clears all state immediately. busy=0, done=0, fifo_r_en=0, arr_valid=0, arr_data=0, FSM=IDLE, counters=0. This also applies mid-pass: the partial pass is discarded and no done is generated.
- FIFO contract: fifo_data_out is registered. Data is valid the cycle after fifo_r_en is high.
- FSM states and transitions:
  - IDLE: when start=1, go to STREAM and set busy=1 on the next edge.
  - STREAM: pop_ok = ~|fifo_empty. All fifo_r_en bits = pop_ok. The bits are never split, and are never high when any empty flag is high. read_cnt increments on each pop. On the pop that makes read_cnt reach VEC_LEN, go to DRAIN.
  - DRAIN: fifo_r_en=0. Wait exactly ROWS cycles, which covers the 1-cycle read latency plus ROWS-1 of skew. Then go to DONE.
  - DONE: done=1 for one cycle, busy=0. Return to IDLE. start in this cycle is ignored.
- start while busy: ignored, no effect.
- Skew pipeline:
  - Stage 0 captures {pop_d1, fifo_data_out}, where pop_d1 is pop_ok delayed one cycle.
  - Row r output = stage-0 value delayed r further cycles via a per-row shift register (row 0 has no extra delay).
  - The pipeline advances every cycle, including stalls. A stall propagates as valid=0 along the same diagonal.
  - arr_valid[r] = delayed valid. arr_data[r] = delayed data. arr_data content when valid=0 is don't-care; the bench must not check it.
- Latency: an element popped at edge t (r_en high in cycle t) appears on row r with arr_valid[r]=1 in cycle t+1+r.
- Count rules: read_cnt width = $clog2(VEC_LEN+1). Exactly VEC_LEN pops per pass. Exactly VEC_LEN valid beats per row per pass. No extra pops after the last.
- Boundary conditions:
  - All FIFOs empty indefinitely: stays in STREAM with r_en=0 and no timeout.
  - One FIFO goes empty mid-pass: the whole column stalls.
  - FIFO refills on the same cycle: pop_ok evaluates combinationally from that cycle's flags.
- ROWS=1: no skew; DRAIN lasts 1 cycle.

Test Plan:
1. Basic pass, ROWS=4, VEC_LEN=8. FIFO r preloaded with r*16+k, k=0..7. Pulse start. -> r_en high for 8 consecutive cycles. Row 0 valid beats = 0..7. Row 3 valid beats = 48..55, with row 3 first beat 3 cycles after row 0 first beat. done pulses once, ROWS cycles after the last pop. busy falls with done.
2. Stall: FIFO 2 empty for 3 cycles after the 4th pop. -> all r_en=0 for those 3 cycles. Each row shows a 3-cycle valid gap after its 4th beat, offset by r. The data sequence is unchanged. done is delayed 3 cycles relative to scenario 1.
3. start asserted during STREAM and during DONE. -> ignored. Exactly one pass, exactly 8 beats per row, a single done.
4. rstn deasserted asynchronously after the 5th pop, then released, then a new start with fresh FIFO contents (values 100+k). -> all outputs 0 immediately on reset assertion. No done for the aborted pass. The new pass outputs 100..107 on row 0 with correct skew.
5. Start with all FIFOs empty for 10 cycles, then filled. -> busy=1 and r_en=0 throughout the wait. Streaming starts on the first cycle all fifo_empty=0.
6. Protocol assertions: r_en is never high while any fifo_empty=1. r_en bits are always equal. Per-row valid count equals VEC_LEN on each pass.
